frame_receiver: RTL and testbench

//   Receive end of the SIG/SYNC 4-bit serial frame link driven by the pattern generator.

---
 rtl/frame_receiver.sv | 138 +++++++++++++
 tb/tb_frame_receiver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/frame_receiver.sv
// Receive side of the SIG/SYNC 4-bit serial frame link: deserializes, decodes the
// 2-bit mode code, flags pattern matches and broken framing, counts good frames.
module frame_receiver #(
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned RESTART_ON_SYNC = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIG,
    input  logic             SYNC,
    input  logic [3:0]       PAT,
    output logic [3:0]       DATA,
    output logic [1:0]       MODE,
    output logic             MODE_OK,
    output logic             VALID,
    output logic             MATCH,
    output logic             FRAME_ERR,
    output logic             BUSY,
    output logic [CNT_W-1:0] FRAME_CNT
);

    typedef enum logic {
        IDLE = 1'b0,
        RX   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [2:0]       shreg, shreg_nxt;
    logic [3:0]       data_nxt;
    logic [1:0]       mode_nxt;
    logic             mode_ok_nxt;
    logic             valid_nxt;
    logic             match_nxt;
    logic             err_nxt;
    logic             busy_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       frame;
    logic [1:0]       dec_mode;
    logic             dec_ok;

    // Frame as it would look if the current SIG bit is the last one
    assign frame = {SIG, shreg};

    always_comb begin
        dec_mode = 2'b00;
        dec_ok   = 1'b1;
        case (frame)
            4'b1001: dec_mode = 2'b00;
            4'b0110: dec_mode = 2'b01;
            4'b0101: dec_mode = 2'b10;
            4'b1111: dec_mode = 2'b11;
            default: dec_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= 2'd0;
            shreg     <= 3'd0;
            DATA      <= 4'd0;
            MODE      <= 2'd0;
            MODE_OK   <= 1'b0;
            VALID     <= 1'b0;
            MATCH     <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY      <= 1'b0;
            FRAME_CNT <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            DATA      <= data_nxt;
            MODE      <= mode_nxt;
            MODE_OK   <= mode_ok_nxt;
            VALID     <= valid_nxt;
            MATCH     <= match_nxt;
            FRAME_ERR <= err_nxt;
            BUSY      <= busy_nxt;
            FRAME_CNT <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        shreg_nxt   = shreg;
        data_nxt    = DATA;
        mode_nxt    = MODE;
        mode_ok_nxt = MODE_OK;
        valid_nxt   = 1'b0;
        match_nxt   = 1'b0;
        err_nxt     = 1'b0;
        busy_nxt    = BUSY;
        cnt_nxt     = FRAME_CNT;
        case (state)
            IDLE: begin
                if (SYNC) begin
                    shreg_nxt = {2'b00, SIG};
                    idx_nxt   = 2'd1;
                    state_nxt = RX;
                    busy_nxt  = 1'b1;
                end
            end
            RX: begin
                if (SYNC && (RESTART_ON_SYNC != 0)) begin
                    // Abort the partial frame and treat this bit as a fresh bit0
                    err_nxt   = 1'b1;
                    shreg_nxt = {2'b00, SIG};
                    idx_nxt   = 2'd1;
                    busy_nxt  = 1'b1;
                end else if (idx == 2'd3) begin
                    data_nxt    = frame;
                    mode_nxt    = dec_mode;
                    mode_ok_nxt = dec_ok;
                    valid_nxt   = 1'b1;
                    match_nxt   = (frame == PAT);
                    state_nxt   = IDLE;
                    idx_nxt     = 2'd0;
                    busy_nxt    = 1'b0;
                    if (dec_ok && (FRAME_CNT != CNT_MAX))
                        cnt_nxt = FRAME_CNT + CNT_W'(1);
                end else begin
                    if (idx == 2'd1)
                        shreg_nxt[1] = SIG;
                    else
                        shreg_nxt[2] = SIG;
                    idx_nxt = idx + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: hand-computed frames, pattern matches,
// restart on mid-frame SYNC, illegal codes, reset mid-frame and counter saturation.
module tb_frame_receiver;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SIG;
    logic       SYNC;
    logic [3:0] PAT;

    logic [3:0] DATA, data2;
    logic [1:0] MODE, mode2;
    logic       MODE_OK, VALID, MATCH, FRAME_ERR, BUSY;
    logic       mode_ok2, valid2, match2, err2, busy2;
    logic [7:0] FRAME_CNT;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    frame_receiver #(.CNT_W(8), .RESTART_ON_SYNC(1)) dut (
        .CLK(CLK), .RST(RST), .SIG(SIG), .SYNC(SYNC), .PAT(PAT),
        .DATA(DATA), .MODE(MODE), .MODE_OK(MODE_OK), .VALID(VALID),
        .MATCH(MATCH), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
    );

    // Narrow-counter instance shares all stimulus, used for saturation
    frame_receiver #(.CNT_W(2), .RESTART_ON_SYNC(1)) dut2 (
        .CLK(CLK), .RST(RST), .SIG(SIG), .SYNC(SYNC), .PAT(PAT),
        .DATA(data2), .MODE(mode2), .MODE_OK(mode_ok2), .VALID(valid2),
        .MATCH(match2), .FRAME_ERR(err2), .BUSY(busy2), .FRAME_CNT(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit across one rising edge; outputs are sampled 1ns after it
    task automatic send_bit(input logic s, input logic b);
        SYNC = s;
        SIG  = b;
        @(posedge CLK);
        #1;
    endtask

    // bits[i] is serial bit i
    task automatic send_frame(input logic [3:0] bits);
        send_bit(1'b1, bits[0]);
        send_bit(1'b0, bits[1]);
        send_bit(1'b0, bits[2]);
        send_bit(1'b0, bits[3]);
    endtask

    initial begin
        RST  = 1'b1;
        SIG  = 1'b0;
        SYNC = 1'b0;
        PAT  = 4'b0000;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst_data",  32'(DATA), 32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_busy",  32'(BUSY), 32'h0);
        check("rst_cnt",   32'(FRAME_CNT), 32'h0);
        RST = 1'b0;
        send_bit(1'b0, 1'b1);
        check("idle_ignore_busy", 32'(BUSY), 32'h0);

        // 1: SIG 1,0,0,1 -> DATA 1001, mode 00
        send_bit(1'b1, 1'b1);
        check("t1_busy", 32'(BUSY), 32'h1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        check("t1_no_valid_early", 32'(VALID), 32'h0);
        send_bit(1'b0, 1'b1);
        check("t1_valid",   32'(VALID), 32'h1);
        check("t1_data",    32'(DATA), 32'h9);
        check("t1_mode",    32'(MODE), 32'h0);
        check("t1_mode_ok", 32'(MODE_OK), 32'h1);
        check("t1_match",   32'(MATCH), 32'h0);
        check("t1_busy0",   32'(BUSY), 32'h0);
        check("t1_cnt",     32'(FRAME_CNT), 32'h1);
        send_bit(1'b0, 1'b0);
        check("t1_valid_pulse", 32'(VALID), 32'h0);
        check("t1_data_hold",   32'(DATA), 32'h9);

        // 2: pattern match on 0110, then 1111 without match
        PAT = 4'b0110;
        send_frame(4'b0110);
        check("t2_valid", 32'(VALID), 32'h1);
        check("t2_data",  32'(DATA), 32'h6);
        check("t2_mode",  32'(MODE), 32'h1);
        check("t2_match", 32'(MATCH), 32'h1);
        send_bit(1'b0, 1'b0);
        check("t2_match_pulse", 32'(MATCH), 32'h0);
        send_frame(4'b1111);
        check("t2b_mode",  32'(MODE), 32'h3);
        check("t2b_match", 32'(MATCH), 32'h0);
        check("t2b_cnt",   32'(FRAME_CNT), 32'h3);

        // 3: back-to-back 1,0,1,0 then 1,1,1,1
        send_bit(1'b0, 1'b0);
        send_frame(4'b0101);
        check("t3_valid_a", 32'(VALID), 32'h1);
        check("t3_mode_a",  32'(MODE), 32'h2);
        send_bit(1'b1, 1'b1);
        check("t3_gap_valid", 32'(VALID), 32'h0);
        check("t3_gap_busy",  32'(BUSY), 32'h1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        check("t3_valid_b", 32'(VALID), 32'h1);
        check("t3_mode_b",  32'(MODE), 32'h3);
        check("t3_cnt",     32'(FRAME_CNT), 32'h5);

        // 4: SYNC, two bits, SYNC again -> FRAME_ERR, then 1,0,0,1 completes
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        check("t4_err",       32'(FRAME_ERR), 32'h1);
        check("t4_err_valid", 32'(VALID), 32'h0);
        check("t4_data_hold", 32'(DATA), 32'hF);
        check("t4_busy",      32'(BUSY), 32'h1);
        send_bit(1'b0, 1'b0);
        check("t4_err_pulse", 32'(FRAME_ERR), 32'h0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        check("t4_valid", 32'(VALID), 32'h1);
        check("t4_data",  32'(DATA), 32'h9);
        check("t4_cnt",   32'(FRAME_CNT), 32'h6);

        // 5: illegal code 0,0,1,1, then reset mid-frame
        send_frame(4'b1100);
        check("t5_valid",   32'(VALID), 32'h1);
        check("t5_mode_ok", 32'(MODE_OK), 32'h0);
        check("t5_mode",    32'(MODE), 32'h0);
        check("t5_data",    32'(DATA), 32'hC);
        check("t5_cnt",     32'(FRAME_CNT), 32'h6);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        RST = 1'b1;
        send_bit(1'b1, 1'b1);
        check("t5_rst_err",   32'(FRAME_ERR), 32'h0);
        check("t5_rst_valid", 32'(VALID), 32'h0);
        check("t5_rst_busy",  32'(BUSY), 32'h0);
        check("t5_rst_data",  32'(DATA), 32'h0);
        check("t5_rst_cnt",   32'(FRAME_CNT), 32'h0);
        RST = 1'b0;
        send_bit(1'b0, 1'b0);
        check("t5_idle_after_rst", 32'(BUSY), 32'h0);

        // 6: five legal frames, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            send_frame(4'b1001);
            check("t6_cnt2", 32'(cnt2), (i < 3) ? 32'(i + 1) : 32'h3);
            check("t6_cnt8", 32'(FRAME_CNT), 32'(i + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
